// File: rtl/panda_decode_stage.sv
// panda_decode_stage: registered RV32I decode stage with an in-order output FIFO.
// Decodes RV32I plus FENCE/ECALL/EBREAK; RV32E register restriction via the RV32E
// parameter. Optional RV32M decode is enabled by defining PANDA_RV32M_EN.
// The decoded bundle (not the raw word) is queued; a flush drops everything queued.

package panda_pkg;

    typedef enum logic [1:0] {
        OP_A_RS1  = 2'd0,
        OP_A_PC   = 2'd1,
        OP_A_ZERO = 2'd2
    } op_a_sel_e;

    typedef enum logic {
        OP_B_RS2 = 1'b0,
        OP_B_IMM = 1'b1
    } op_b_sel_e;

    typedef enum logic [1:0] {
        RD_ALU = 2'd0,
        RD_LSU = 2'd1,
        RD_PC4 = 2'd2,
        RD_MD  = 2'd3
    } rd_data_sel_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NE   = 4'd11,
        ALU_LT   = 4'd12,
        ALU_GE   = 4'd13,
        ALU_LTU  = 4'd14,
        ALU_GEU  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2
    } lsu_width_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0]  pc;
        logic [4:0]   rs1_addr;
        logic [4:0]   rs2_addr;
        logic [4:0]   rd_addr;
        logic         rd_we;
        logic         lsu_store;
        logic         branch;
        logic         jump;
        op_a_sel_e    op_a_sel;
        op_b_sel_e    op_b_sel;
        rd_data_sel_e rd_data_sel;
        alu_op_e      alu_op;
        lsu_width_e   lsu_width;
        logic         lsu_unsigned;
        logic [31:0]  imm;
        logic         md_en;
        logic [2:0]   md_op;
        logic         ecall;
        logic         ebreak;
        logic         illegal;
    } decode_t;

endpackage

module panda_decode_stage
    import panda_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned RV32E = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              in_instr_i,
    input  logic [31:0]              in_pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_pc_o,
    output logic [4:0]               rs1_addr_o,
    output logic [4:0]               rs2_addr_o,
    output logic [4:0]               rd_addr_o,
    output logic                     rd_we_o,
    output logic                     lsu_store_o,
    output logic                     branch_o,
    output logic                     jump_o,
    output op_a_sel_e                op_a_sel_o,
    output op_b_sel_e                op_b_sel_o,
    output rd_data_sel_e             rd_data_sel_o,
    output alu_op_e                  alu_operator_o,
    output lsu_width_e               lsu_width_o,
    output logic                     lsu_load_unsigned_o,
    output logic [31:0]              imm_o,
    output logic                     md_en_o,
    output logic [2:0]               md_op_o,
    output logic                     ecall_o,
    output logic                     ebreak_o,
    output logic                     illegal_instr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Register-register / register-immediate ALU operation selected by funct3.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Full combinational decode of one instruction word into a bundle.
    function automatic decode_t decode_instr(input logic [31:0] instr, input logic [31:0] pc);
        decode_t    d;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       use_rs1;
        logic       use_rs2;
        logic       use_rd;
        opcode  = instr[6:0];
        funct3  = instr[14:12];
        funct7  = instr[31:25];
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        d              = '0;
        d.pc           = pc;
        d.rs1_addr     = instr[19:15];
        d.rs2_addr     = instr[24:20];
        d.rd_addr      = instr[11:7];
        d.op_a_sel     = OP_A_RS1;
        d.op_b_sel     = OP_B_RS2;
        d.rd_data_sel  = RD_ALU;
        d.alu_op       = ALU_ADD;
        d.lsu_width    = LSU_BYTE;

        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                d.rd_we    = 1'b1;
                d.op_a_sel = (opcode == OPC_LUI) ? OP_A_ZERO : OP_A_PC;
                d.op_b_sel = OP_B_IMM;
                d.imm      = {instr[31:12], 12'h000};
                use_rd     = 1'b1;
            end
            OPC_JAL: begin
                d.jump        = 1'b1;
                d.rd_we       = 1'b1;
                d.rd_data_sel = RD_PC4;
                d.op_a_sel    = OP_A_PC;
                d.op_b_sel    = OP_B_IMM;
                d.imm         = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                use_rd        = 1'b1;
            end
            OPC_JALR: begin
                d.jump        = 1'b1;
                d.rd_we       = 1'b1;
                d.rd_data_sel = RD_PC4;
                d.op_b_sel    = OP_B_IMM;
                d.imm         = {{20{instr[31]}}, instr[31:20]};
                d.illegal     = (funct3 != 3'b000);
                use_rs1       = 1'b1;
                use_rd        = 1'b1;
            end
            OPC_BRANCH: begin
                d.branch = 1'b1;
                d.imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                case (funct3)
                    3'b000:  d.alu_op = ALU_EQ;
                    3'b001:  d.alu_op = ALU_NE;
                    3'b100:  d.alu_op = ALU_LT;
                    3'b101:  d.alu_op = ALU_GE;
                    3'b110:  d.alu_op = ALU_LTU;
                    3'b111:  d.alu_op = ALU_GEU;
                    default: d.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d.rd_we        = 1'b1;
                d.rd_data_sel  = RD_LSU;
                d.op_b_sel     = OP_B_IMM;
                d.imm          = {{20{instr[31]}}, instr[31:20]};
                d.lsu_width    = lsu_width_e'(funct3[1:0]);
                d.lsu_unsigned = funct3[2];
                d.illegal      = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
                use_rs1        = 1'b1;
                use_rd         = 1'b1;
            end
            OPC_STORE: begin
                d.lsu_store = 1'b1;
                d.op_b_sel  = OP_B_IMM;
                d.imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                d.lsu_width = lsu_width_e'(funct3[1:0]);
                d.illegal   = (funct3[2] == 1'b1) || (funct3[1:0] == 2'b11);
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            OPC_OP_IMM: begin
                d.rd_we    = 1'b1;
                d.op_b_sel = OP_B_IMM;
                d.imm      = {{20{instr[31]}}, instr[31:20]};
                d.alu_op   = alu_from_funct3(funct3);
                use_rs1    = 1'b1;
                use_rd     = 1'b1;
                if (funct3 == 3'b001) begin
                    d.illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    d.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    d.alu_op  = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                end else begin
                    d.illegal = 1'b0;
                end
            end
            OPC_OP: begin
                d.rd_we = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                case (funct7)
                    7'b0000000: d.alu_op = alu_from_funct3(funct3);
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            d.alu_op = ALU_SUB;
                        end else if (funct3 == 3'b101) begin
                            d.alu_op = ALU_SRA;
                        end else begin
                            d.illegal = 1'b1;
                        end
                    end
                    7'b0000001: begin
`ifdef PANDA_RV32M_EN
                        d.md_en       = 1'b1;
                        d.md_op       = funct3;
                        d.rd_data_sel = RD_MD;
                        d.op_a_sel    = OP_A_RS1;
                        d.op_b_sel    = OP_B_RS2;
`else
                        d.illegal = 1'b1;
`endif
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            OPC_FENCE: begin
                // Memory ordering is trivially satisfied by this in-order pipe.
                d.illegal = 1'b0;
            end
            OPC_SYSTEM: begin
                if (instr == 32'h0000_0073) begin
                    d.ecall = 1'b1;
                end else if (instr == 32'h0010_0073) begin
                    d.ebreak = 1'b1;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            default: d.illegal = 1'b1;
        endcase

        if ((RV32E != 0) && ((use_rs1 && instr[19]) || (use_rs2 && instr[24]) || (use_rd && instr[11]))) begin
            d.illegal = 1'b1;
        end else begin
            d.illegal = d.illegal;
        end

        // An illegal entry must never cause architectural side effects downstream.
        if (d.illegal) begin
            d.rd_we     = 1'b0;
            d.lsu_store = 1'b0;
            d.branch    = 1'b0;
            d.jump      = 1'b0;
            d.md_en     = 1'b0;
            d.md_op     = 3'b000;
            d.ecall     = 1'b0;
            d.ebreak    = 1'b0;
        end else begin
            d.md_op = d.md_op;
        end
        return d;
    endfunction

    decode_t            mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    decode_t            dec_s;
    decode_t            head_s;
    logic               push_s;
    logic               pop_s;
    logic               in_ready_s;
    logic               out_valid_s;

    assign in_ready_s  = (count_r != CNT_W'(DEPTH));
    assign out_valid_s = (count_r != {CNT_W{1'b0}});
    assign push_s      = in_valid_i && in_ready_s && !flush_i;
    assign pop_s       = out_valid_s && out_ready_i;

    // Decode the incoming word so the bundle can be stored on push.
    always_comb begin
        dec_s = decode_instr(in_instr_i, in_pc_i);
    end

    // Bundle storage; occupancy gating on the read side makes a reset unnecessary here.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= dec_s;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Present the head entry, or all zeros when nothing is queued.
    always_comb begin
        head_s = '0;
        if (out_valid_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign in_ready_o          = in_ready_s;
    assign out_valid_o         = out_valid_s;
    assign count_o             = count_r;
    assign out_pc_o            = head_s.pc;
    assign rs1_addr_o          = head_s.rs1_addr;
    assign rs2_addr_o          = head_s.rs2_addr;
    assign rd_addr_o           = head_s.rd_addr;
    assign rd_we_o             = head_s.rd_we;
    assign lsu_store_o         = head_s.lsu_store;
    assign branch_o            = head_s.branch;
    assign jump_o              = head_s.jump;
    assign op_a_sel_o          = head_s.op_a_sel;
    assign op_b_sel_o          = head_s.op_b_sel;
    assign rd_data_sel_o       = head_s.rd_data_sel;
    assign alu_operator_o      = head_s.alu_op;
    assign lsu_width_o         = head_s.lsu_width;
    assign lsu_load_unsigned_o = head_s.lsu_unsigned;
    assign imm_o               = head_s.imm;
    assign md_en_o             = head_s.md_en;
    assign md_op_o             = head_s.md_op;
    assign ecall_o             = head_s.ecall;
    assign ebreak_o            = head_s.ebreak;
    assign illegal_instr_o     = head_s.illegal;

endmodule

// File: tb/tb_panda_decode_stage.sv
// Testbench for panda_decode_stage: directed scenarios followed by randomized
// traffic checked against a queue-based reference model of the decode stage.
module tb_panda_decode_stage;
    import panda_pkg::*;

`ifdef PANDA_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: DEPTH=2, RV32E=0
    logic flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [4:0] rs1, rs2, rd;
    logic rd_we, st, br, jmp, ld_u, md_en, ecall, ebreak, illegal;
    logic [2:0] md_op;
    logic [1:0] count;
    op_a_sel_e op_a; op_b_sel_e op_b; rd_data_sel_e rd_sel; alu_op_e alu; lsu_width_e lsu_w;

    panda_decode_stage #(.DEPTH(DEPTH), .RV32E(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .rs1_addr_o(rs1), .rs2_addr_o(rs2), .rd_addr_o(rd), .rd_we_o(rd_we),
        .lsu_store_o(st), .branch_o(br), .jump_o(jmp), .op_a_sel_o(op_a), .op_b_sel_o(op_b),
        .rd_data_sel_o(rd_sel), .alu_operator_o(alu), .lsu_width_o(lsu_w), .lsu_load_unsigned_o(ld_u),
        .imm_o(imm), .md_en_o(md_en), .md_op_o(md_op), .ecall_o(ecall), .ebreak_o(ebreak),
        .illegal_instr_o(illegal), .count_o(count));

    // Second DUT: RV32E=1, DEPTH=4
    logic e_flush, e_in_valid, e_in_ready, e_out_valid, e_out_ready;
    logic [31:0] e_in_instr, e_in_pc, e_out_pc, e_imm;
    logic [4:0] e_rs1, e_rs2, e_rd;
    logic e_rd_we, e_st, e_br, e_jmp, e_ld_u, e_md_en, e_ecall, e_ebreak, e_illegal;
    logic [2:0] e_md_op;
    logic [2:0] e_count;
    op_a_sel_e e_op_a; op_b_sel_e e_op_b; rd_data_sel_e e_rd_sel; alu_op_e e_alu; lsu_width_e e_lsu_w;

    panda_decode_stage #(.DEPTH(4), .RV32E(1)) dut_e (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(e_flush), .in_valid_i(e_in_valid), .in_ready_o(e_in_ready),
        .in_instr_i(e_in_instr), .in_pc_i(e_in_pc), .out_valid_o(e_out_valid), .out_ready_i(e_out_ready),
        .out_pc_o(e_out_pc), .rs1_addr_o(e_rs1), .rs2_addr_o(e_rs2), .rd_addr_o(e_rd), .rd_we_o(e_rd_we),
        .lsu_store_o(e_st), .branch_o(e_br), .jump_o(e_jmp), .op_a_sel_o(e_op_a), .op_b_sel_o(e_op_b),
        .rd_data_sel_o(e_rd_sel), .alu_operator_o(e_alu), .lsu_width_o(e_lsu_w), .lsu_load_unsigned_o(e_ld_u),
        .imm_o(e_imm), .md_en_o(e_md_en), .md_op_o(e_md_op), .ecall_o(e_ecall), .ebreak_o(e_ebreak),
        .illegal_instr_o(e_illegal), .count_o(e_count));

    typedef struct packed {
        logic        illegal, rd_we, store, branch, jump, ecall, ebreak, md_en;
        logic [2:0]  md_op;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [31:0] pc;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t model_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] alu_f3(input logic [2:0] f3);
        case (f3)
            3'd0: return ALU_ADD;   3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;   3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;   3'd5: return ALU_SRL;
            3'd6: return ALU_OR;    default: return ALU_AND;
        endcase
    endfunction

    // Reference decode straight from the ISA rules.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit rv32e);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok, u1, u2, ud;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        e = '0; e.pc = pc; e.rd = w[11:7]; e.alu = ALU_ADD;
        ok = 1'b1; u1 = 1'b0; u2 = 1'b0; ud = 1'b0;
        case (op)
            7'h37, 7'h17: begin e.rd_we = 1; e.imm = {w[31:12], 12'h000}; ud = 1; end
            7'h6F: begin
                e.jump = 1; e.rd_we = 1; ud = 1;
                e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            end
            7'h67: begin e.jump = 1; e.rd_we = 1; e.imm = 32'($signed(w[31:20])); ok = (f3 == 0); u1 = 1; ud = 1; end
            7'h63: begin
                e.branch = 1; u1 = 1; u2 = 1;
                e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                ok = !(f3 == 2 || f3 == 3);
                case (f3)
                    3'd0: e.alu = ALU_EQ;  3'd1: e.alu = ALU_NE;
                    3'd4: e.alu = ALU_LT;  3'd5: e.alu = ALU_GE;
                    3'd6: e.alu = ALU_LTU; default: e.alu = ALU_GEU;
                endcase
            end
            7'h03: begin e.rd_we = 1; e.imm = 32'($signed(w[31:20])); ok = (f3 inside {0, 1, 2, 4, 5}); u1 = 1; ud = 1; end
            7'h23: begin e.store = 1; e.imm = 32'($signed({w[31:25], w[11:7]})); ok = (f3 <= 2); u1 = 1; u2 = 1; end
            7'h13: begin
                e.rd_we = 1; e.imm = 32'($signed(w[31:20])); e.alu = alu_f3(f3); u1 = 1; ud = 1;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin ok = (f7 == 0 || f7 == 7'h20); e.alu = (f7 == 7'h20) ? ALU_SRA : ALU_SRL; end
            end
            7'h33: begin
                e.rd_we = 1; u1 = 1; u2 = 1; ud = 1;
                if (f7 == 0) e.alu = alu_f3(f3);
                else if (f7 == 7'h20) begin ok = (f3 == 0 || f3 == 5); e.alu = (f3 == 0) ? ALU_SUB : ALU_SRA; end
                else if (f7 == 7'h01) begin ok = M_EN; e.md_en = 1; e.md_op = f3; end
                else ok = 0;
            end
            7'h0F: ok = 1;
            7'h73: begin
                if (w == 32'h73) e.ecall = 1;
                else if (w == 32'h100073) e.ebreak = 1;
                else ok = 0;
            end
            default: ok = 0;
        endcase
        if (rv32e && ((u1 && w[19]) || (u2 && w[24]) || (ud && w[11]))) ok = 0;
        if (!ok) begin
            e.illegal = 1;
            e.rd_we = 0; e.store = 0; e.branch = 0; e.jump = 0;
            e.ecall = 0; e.ebreak = 0; e.md_en = 0; e.md_op = 0;
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = '{illegal: illegal, rd_we: rd_we, store: st, branch: br, jump: jmp, ecall: ecall,
              ebreak: ebreak, md_en: md_en, md_op: md_op, imm: imm, alu: alu, rd: rd, pc: out_pc};
        return o;
    endfunction

    // Random instruction, biased towards each opcode's interesting encodings.
    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [6:0] opc [11];
        int sel;
        opc = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        r = $urandom;
        sel = $urandom_range(0, 11);
        if (sel == 11) return r;
        r[6:0] = opc[sel];
        if (sel == 3 && $urandom_range(0, 3) != 0) r[14:12] = 3'd0;
        if (sel == 7 && $urandom_range(0, 2) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if (sel == 8) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00; 1: r[31:25] = 7'h20; 2: r[31:25] = 7'h01; default: r[31:25] = r[31:25];
            endcase
        end
        if (sel == 10) begin
            case ($urandom_range(0, 2))
                0: r = 32'h0000_0073; 1: r = 32'h0010_0073; default: r[6:0] = 7'h73;
            endcase
        end
        return r;
    endfunction

    initial begin
        exp_t e, o;
        logic [31:0] w;
        bit do_push, do_pop;
        flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
        e_flush = 0; e_in_valid = 0; e_out_ready = 1; e_in_instr = 0; e_in_pc = 0;
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_bundle", {out_pc, imm, rd_we, illegal, 4'(alu)}, 0);
        rst_n = 1;
        step();

        // ADDI x1,x2,-1
        in_valid = 1; in_instr = 32'hFFF1_0093; in_pc = 32'h100;
        step();
        in_valid = 0;
        chk("addi_valid", out_valid, 1);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_rs1", rs1, 2);
        chk("addi_rd", rd, 1);
        chk("addi_imm", imm, 32'hFFFF_FFFF);
        chk("addi_alu", alu, ALU_ADD);
        chk("addi_we", rd_we, 1);
        out_ready = 1; step(); out_ready = 0;
        chk("addi_drained", count, 0);

        // Backpressure with three pushes
        in_valid = 1; in_instr = 32'h0011_0093; in_pc = 32'h200; step();
        in_pc = 32'h204; step();
        chk("bp_full_ready", in_ready, 0);
        chk("bp_full_count", count, 2);
        in_pc = 32'h208; step();
        chk("bp_hold_count", count, 2);
        chk("bp_head_a", out_pc, 32'h200);
        out_ready = 1; step();
        chk("bp_head_b", out_pc, 32'h204);
        chk("bp_count_1", count, 1);
        step();
        in_valid = 0;
        chk("bp_head_c", out_pc, 32'h208);
        chk("bp_count_c", count, 1);
        step(); out_ready = 0;
        chk("bp_empty", out_valid, 0);

        // Flush with two queued and a same-cycle push
        in_valid = 1; in_pc = 32'h300; step(); in_pc = 32'h304; step();
        flush = 1; in_pc = 32'h308; step();
        flush = 0; in_valid = 0;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_pc", out_pc, 0);
        step();
        chk("flush_dropped", count, 0);

        // Illegal zero word, EBREAK, MUL
        out_ready = 1; in_valid = 1; in_instr = 32'h0; in_pc = 32'h400; step();
        chk("zero_illegal", {illegal, rd_we}, 2'b10);
        in_instr = 32'h0010_0073; step();
        chk("ebreak", {ebreak, illegal}, 2'b10);
        in_instr = 32'h0220_81B3; step();
        in_valid = 0;
        chk("mul_md_en", md_en, M_EN);
        chk("mul_illegal_we", {illegal, rd_we}, {!M_EN, M_EN});
        chk("mul_rd_md_op", {rd, md_op}, {5'd3, 3'd0});
        step(); out_ready = 0;

        // RV32E restriction
        e_in_valid = 1; e_in_instr = 32'h0000_0833; step();
        chk("e_x16_illegal", e_illegal, 1);
        e_in_instr = 32'h0000_07B3; step();
        e_in_valid = 0;
        chk("e_x15_legal", {e_illegal, e_rd_we, e_rd}, {1'b0, 1'b1, 5'd15});

        // Asynchronous reset mid-operation
        in_valid = 1; in_instr = 32'h0011_0093; step(); in_valid = 0;
        rst_n = 0; #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_count", count, 0);
        step(); rst_n = 1; step();

        // Randomized traffic against the queue model
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (model_q.size() > 0) begin
                e = model_q[0];
                o = observed();
                chk("rnd_valid", out_valid, 1);
                if (e.illegal) begin
                    e.imm = 0; e.alu = 0; e.rd = 0; o.imm = 0; o.alu = 0; o.rd = 0;
                end
                chk("rnd_bundle", o, e);
            end else begin
                chk("rnd_empty", {out_valid, out_pc, illegal}, 0);
            end
            chk("rnd_count", count, model_q.size());
            chk("rnd_ready", in_ready, model_q.size() != DEPTH);
            w = gen_instr();
            in_instr = w;
            in_pc = $urandom & 32'hFFFF_FFFC;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            do_push = in_valid && (model_q.size() < DEPTH) && !flush;
            do_pop = (model_q.size() > 0) && out_ready;
            if (flush) model_q.delete();
            else begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) model_q.push_back(ref_decode(w, in_pc, 1'b0));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
